// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, single-entry
// instruction buffer toward decode, and redirect handling for bpu_flush.
module inst_fetch_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] BOOT_ADDR,
   input  logic [ADDR_WIDTH-1:0] pcgen_pc,
   input  logic                  bpu_flush,
   input  logic [ADDR_WIDTH-1:0] bpu_target,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [ADDR_WIDTH-1:0] imem_rsp_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic [ADDR_WIDTH-1:0] inst,
   output logic                  inst_fire
);

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   fetch_addr_q;
   logic [ADDR_WIDTH-1:0]   fetch_addr_d;
   logic [ADDR_WIDTH-1:0]   inst_q;
   logic [ADDR_WIDTH-1:0]   inst_d;
   logic [ADDR_WIDTH-1:0]   inst_pc_q;
   logic [ADDR_WIDTH-1:0]   inst_pc_d;

   function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
      return a & ~(ADDR_WIDTH'(3));
   endfunction

   // In DROP fetch_addr_q already holds the redirect target, so it doubles as
   // the stored target and no separate register is needed.
   assign imem_req_valid = (state_q == ST_REQ);
   assign imem_req_addr  = fetch_addr_q;
   assign inst_valid     = (state_q == ST_HOLD);
   assign inst_pc        = inst_pc_q;
   assign inst           = inst_q;
   assign inst_fire      = inst_valid & inst_ready & ~bpu_flush;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      case (state_q)
         ST_BOOT: begin
            fetch_addr_d = bpu_flush ? align_word(bpu_target) : align_word(BOOT_ADDR);
            state_d      = ST_REQ;
         end
         ST_REQ: begin
            if (bpu_flush) begin
               fetch_addr_d = align_word(bpu_target);
               // A request accepted in the flush cycle still owes a response.
               state_d      = imem_req_ready ? ST_DROP : ST_REQ;
            end else if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bpu_flush) begin
               fetch_addr_d = align_word(bpu_target);
               state_d      = imem_rsp_valid ? ST_REQ : ST_DROP;
            end else if (imem_rsp_valid) begin
               inst_d    = imem_rsp_data;
               inst_pc_d = fetch_addr_q;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bpu_flush) begin
               fetch_addr_d = align_word(bpu_target);
               state_d      = ST_REQ;
            end else if (inst_ready) begin
               fetch_addr_d = align_word(pcgen_pc);
               state_d      = ST_REQ;
            end
         end
         ST_DROP: begin
            if (bpu_flush) begin
               fetch_addr_d = align_word(bpu_target);
            end
            if (imem_rsp_valid) begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_BOOT;
         fetch_addr_q <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with an inline memory model and a
// scoreboard of {pc, word} pairs expected at each inst_fire.
module tb_inst_fetch_ctrl;

   logic        CLK;
   logic        RST;
   logic [31:0] BOOT_ADDR;
   logic [31:0] pcgen_pc;
   logic        bpu_flush;
   logic [31:0] bpu_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst;
   logic        inst_fire;

   inst_fetch_ctrl #(.ADDR_WIDTH(32)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .BOOT_ADDR      (BOOT_ADDR),
      .pcgen_pc       (pcgen_pc),
      .bpu_flush      (bpu_flush),
      .bpu_target     (bpu_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst           (inst),
      .inst_fire      (inst_fire)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cycle    = 0;
   int          lat      = 1;
   logic        pend     = 1'b0;
   int          cnt      = 0;
   logic [31:0] pdata    = '0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a - 32'h1000) ^ 32'h13;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cycle);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      chk({tag, "_req_addr"},  imem_req_addr,       32'd0);
      chk({tag, "_inst_valid"}, 32'(inst_valid),    32'd0);
      chk({tag, "_inst"},      inst,                32'd0);
      chk({tag, "_inst_pc"},   inst_pc,             32'd0);
      chk({tag, "_inst_fire"}, 32'(inst_fire),      32'd0);
   endtask

   // One clock: scoreboard check on fire, memory handshake, then response timing.
   task automatic cyc();
      logic        acc;
      logic [31:0] acc_addr;
      exp_t        e;
      #1;
      if (inst_fire) begin
         chk("fire_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_inst_pc", inst_pc, e.pc);
            chk("sb_inst", inst, e.word);
         end
      end
      acc      = imem_req_valid && imem_req_ready && !RST;
      acc_addr = imem_req_addr;
      if (acc) chk("one_outstanding", 32'(pend), 32'd0);
      @(posedge CLK);
      #1;
      cycle++;
      imem_rsp_valid = 1'b0;
      if (RST) begin
         pend = 1'b0;
      end else if (acc) begin
         pend  = 1'b1;
         cnt   = lat - 1;
         pdata = mem_word(acc_addr);
      end
      if (pend) begin
         if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pdata;
            pend           = 1'b0;
         end else begin
            cnt--;
         end
      end
      if (imem_req_valid) chk("addr_aligned", 32'(imem_req_addr[1:0]), 32'd0);
   endtask

   initial begin
      RST            = 1'b1;
      BOOT_ADDR      = 32'h0000_1000;
      pcgen_pc       = '0;
      bpu_flush      = 1'b0;
      bpu_target     = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      inst_ready     = 1'b1;

      // Reset state and boot fetch
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outputs("rst");
      RST      = 1'b0;
      cycle    = 0;
      pcgen_pc = 32'h1004;
      sb.push_back('{pc: 32'h1000, word: 32'h0000_0013});
      #1 chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
      cyc();
      chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c1_req_addr", imem_req_addr, 32'h1000);
      cyc();
      chk("c2_req_valid", 32'(imem_req_valid), 32'd0);
      chk("c2_inst_valid", 32'(inst_valid), 32'd0);
      cyc();
      chk("c3_inst_valid", 32'(inst_valid), 32'd1);
      chk("c3_inst_pc", inst_pc, 32'h1000);
      chk("c3_inst", inst, 32'h13);
      chk("c3_fire", 32'(inst_fire), 32'd1);

      // Decode stalls for 5 cycles in HOLD
      sb.push_back('{pc: 32'h1004, word: mem_word(32'h1004)});
      cyc();
      chk("c4_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c4_req_addr", imem_req_addr, 32'h1004);
      chk("c4_inst_valid", 32'(inst_valid), 32'd0);
      inst_ready = 1'b0;
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         chk("stall_inst_valid", 32'(inst_valid), 32'd1);
         chk("stall_inst_pc", inst_pc, 32'h1004);
         chk("stall_inst", inst, mem_word(32'h1004));
         chk("stall_no_req", 32'(imem_req_valid), 32'd0);
         chk("stall_no_fire", 32'(inst_fire), 32'd0);
         cyc();
      end
      inst_ready = 1'b1;
      pcgen_pc   = 32'h1009;
      #1 chk("stall_release_fire", 32'(inst_fire), 32'd1);
      sb.push_back('{pc: 32'h1008, word: mem_word(32'h1008)});
      cyc();
      chk("pcgen_req_valid", 32'(imem_req_valid), 32'd1);
      chk("pcgen_aligned_addr", imem_req_addr, 32'h1008);
      chk("pcgen_inst_valid", 32'(inst_valid), 32'd0);

      // Memory backpressure for 3 cycles
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
         chk("bp_req_addr", imem_req_addr, 32'h1008);
         cyc();
      end
      chk("bp_still_req", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      pcgen_pc       = 32'h100C;
      cyc();
      chk("bp_wait_entered", 32'(imem_req_valid), 32'd0);
      cyc();
      chk("bp_hold", 32'(inst_valid), 32'd1);

      // Flush in WAIT, stale response 4 cycles later
      lat = 5;
      cyc();
      chk("w_req_addr", imem_req_addr, 32'h100C);
      cyc();
      chk("w_in_wait", 32'(imem_req_valid), 32'd0);
      bpu_flush  = 1'b1;
      bpu_target = 32'h2000;
      cyc();
      bpu_flush = 1'b0;
      lat       = 1;
      for (int i = 0; i < 4; i++) begin
         chk("drop_no_req", 32'(imem_req_valid), 32'd0);
         chk("drop_no_inst", 32'(inst_valid), 32'd0);
         cyc();
      end
      chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir_req_addr", imem_req_addr, 32'h2000);
      cyc();
      cyc();
      chk("h_inst_valid", 32'(inst_valid), 32'd1);
      chk("h_inst_pc", inst_pc, 32'h2000);

      // Flush in HOLD with decode ready
      bpu_flush  = 1'b1;
      bpu_target = 32'h3000;
      inst_ready = 1'b1;
      #1 chk("hflush_no_fire", 32'(inst_fire), 32'd0);
      cyc();
      bpu_flush = 1'b0;
      chk("hflush_inst_valid", 32'(inst_valid), 32'd0);
      chk("hflush_req_valid", 32'(imem_req_valid), 32'd1);
      chk("hflush_req_addr", imem_req_addr, 32'h3000);

      // Reset while in WAIT
      lat = 3;
      cyc();
      chk("rw_in_wait", 32'(imem_req_valid), 32'd0);
      RST       = 1'b1;
      BOOT_ADDR = 32'h1002;
      #1 chk_reset_outputs("async_rst");
      cyc();
      cyc();
      chk_reset_outputs("held_rst");
      RST   = 1'b0;
      cycle = 0;
      cyc();
      chk("reboot_req_valid", 32'(imem_req_valid), 32'd1);
      chk("reboot_req_addr", imem_req_addr, 32'h1000);

      // Double flush in DROP
      lat = 4;
      cyc();
      bpu_flush  = 1'b1;
      bpu_target = 32'h4000;
      cyc();
      chk("d2_in_drop", 32'(imem_req_valid), 32'd0);
      bpu_target = 32'h5003;
      cyc();
      bpu_flush = 1'b0;
      chk("d2_no_req", 32'(imem_req_valid), 32'd0);
      chk("d2_no_inst", 32'(inst_valid), 32'd0);
      cyc();
      chk("d2_rsp_no_req", 32'(imem_req_valid), 32'd0);
      chk("d2_rsp_no_inst", 32'(inst_valid), 32'd0);
      lat = 1;
      sb.push_back('{pc: 32'h5000, word: mem_word(32'h5000)});
      pcgen_pc = 32'h5004;
      cyc();
      chk("d2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("d2_req_addr", imem_req_addr, 32'h5000);
      cyc();
      cyc();
      chk("d2_hold", 32'(inst_valid), 32'd1);
      cyc();
      chk("d2_next_addr", imem_req_addr, 32'h5004);

      // Flush in REQ without ready, then with ready
      imem_req_ready = 1'b0;
      bpu_flush      = 1'b1;
      bpu_target     = 32'h6000;
      cyc();
      chk("rq_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rq_req_addr", imem_req_addr, 32'h6000);
      bpu_target     = 32'h7000;
      imem_req_ready = 1'b1;
      lat            = 2;
      cyc();
      bpu_flush = 1'b0;
      chk("rqr_in_drop", 32'(imem_req_valid), 32'd0);
      cyc();
      chk("rqr_rsp_no_req", 32'(imem_req_valid), 32'd0);
      chk("rqr_rsp_no_inst", 32'(inst_valid), 32'd0);
      lat = 1;
      cyc();
      chk("rqr_req_addr", imem_req_addr, 32'h7000);
      chk("rqr_req_valid", 32'(imem_req_valid), 32'd1);

      // Flush in WAIT coinciding with the response
      cyc();
      chk("wr_rsp_seen", 32'(imem_rsp_valid), 32'd1);
      bpu_flush  = 1'b1;
      bpu_target = 32'h8000;
      cyc();
      bpu_flush = 1'b0;
      chk("wr_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wr_req_addr", imem_req_addr, 32'h8000);
      chk("wr_no_inst", 32'(inst_valid), 32'd0);
      sb.push_back('{pc: 32'h8000, word: mem_word(32'h8000)});
      pcgen_pc = 32'h8004;
      cyc();
      cyc();
      chk("wr_hold_pc", inst_pc, 32'h8000);
      cyc();
      chk("wr_next_addr", imem_req_addr, 32'h8004);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
